// File: rtl/fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction memory (slave).
// Handshake: imem_req/imem_addr are held stable until imem_ack; imem_ack is the ready and also
// marks imem_rdata valid in that same cycle, and is meaningless while imem_req is low.
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch.sv
// RV32 instruction fetch stage: single-outstanding imem requests, small instruction queue, flush redirect.
// Optional macro FETCH_BYPASS_EN: an acked word goes straight to inst/pc when the queue is empty.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         jal_flush,
  input  logic         branch_flush,
  input  logic [31:0]  jal_target,
  input  logic [31:0]  branch_target,
  fetch_if.master      imem,
  output logic [31:0]  inst,
  output logic [31:0]  pc,
  output logic [1:0]   dbg_state_o
);

  localparam int          PW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int          CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t         state_q;
  logic           req_q;
  logic [31:0]    addr_q;
  logic [31:0]    fpc_q;
  logic [31:0]    inst_q;
  logic [31:0]    pc_q;
  logic [31:0]    q_inst_q [QDEPTH];
  logic [31:0]    q_pc_q   [QDEPTH];
  logic [PW-1:0]  rd_ptr_q;
  logic [PW-1:0]  wr_ptr_q;
  logic [CW-1:0]  count_q;

  logic           flush;
  logic [31:0]    target;
  logic           ack;
  logic           ack_req;
  logic           bypass;
  logic           pop;
  logic           push;
  logic [CW-1:0]  count_d;
  logic [31:0]    fpc_inc;

  assign flush   = jal_flush | branch_flush;
  assign target  = branch_flush ? {branch_target[31:2], 2'b00} : {jal_target[31:2], 2'b00};
  assign ack     = req_q & imem.imem_ack;
  assign ack_req = ack && (state_q == REQ);

`ifdef FETCH_BYPASS_EN
  assign bypass = ack_req && (count_q == '0) && !stall && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign pop     = !flush && !stall && (count_q != '0);
  assign push    = ack_req && !flush && !bypass;
  assign count_d = count_q + CW'(push) - CW'(pop);
  assign fpc_inc = fpc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      fpc_q    <= RESET_PC;
      inst_q   <= NOP;
      pc_q     <= 32'h0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          q_inst_q[wr_ptr_q] <= imem.imem_rdata;
          q_pc_q[wr_ptr_q]   <= fpc_q;
          wr_ptr_q           <= wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_d;
      end

      // Decode register: flush beats stall, so a stalled stale instruction is never held.
      if (flush) begin
        inst_q <= NOP;
      end else if (stall) begin
        inst_q <= inst_q;
      end else if (bypass) begin
        inst_q <= imem.imem_rdata;
        pc_q   <= fpc_q;
      end else if (count_q != '0) begin
        inst_q <= q_inst_q[rd_ptr_q];
        pc_q   <= q_pc_q[rd_ptr_q];
      end else begin
        inst_q <= NOP;
      end

      case (state_q)
        IDLE: begin
          if (flush) begin
            fpc_q <= target;
          end else if (count_q < CW'(QDEPTH)) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            addr_q  <= fpc_q;
          end
        end
        REQ: begin
          if (flush) begin
            fpc_q <= target;
            if (ack) begin
              state_q <= IDLE;
              req_q   <= 1'b0;
            end else begin
              state_q <= DROP;
            end
          end else if (ack) begin
            fpc_q <= fpc_inc;
            if (count_d < CW'(QDEPTH)) begin
              addr_q <= fpc_inc;
            end else begin
              state_q <= IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        DROP: begin
          // The in-flight request must still complete; its data is thrown away.
          if (flush) fpc_q <= target;
          if (ack) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign inst           = inst_q;
  assign pc             = pc_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: per-cycle vector table for streaming/stall/flush, plus hand sequences
// for delayed-ack drop, reset mid-request and address wrap.
module tb_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        jal_flush;
  logic        branch_flush;
  logic [31:0] jal_target;
  logic [31:0] branch_target;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [1:0]  dbg_state;

  fetch_if imem_bus ();

  fetch #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .jal_flush     (jal_flush),
    .branch_flush  (branch_flush),
    .jal_target    (jal_target),
    .branch_target (branch_target),
    .imem          (imem_bus),
    .inst          (inst),
    .pc            (pc),
    .dbg_state_o   (dbg_state)
  );

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  int n_checks = 0;
  int n_fail   = 0;

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // Instruction memory model: answers after mem_lat waiting cycles, data = addr + 0x13 + salt.
  int          mem_lat  = 0;
  logic [31:0] mem_salt = 32'h0;
  logic        spurious = 1'b0;
  logic        saw_200  = 1'b0;
  int          wcnt     = 0;

  initial begin
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'h0;
  end

  always @(posedge clk) begin
    #1;
    if (imem_bus.imem_req) begin
      if (imem_bus.imem_addr == 32'h0000_0200) saw_200 = 1'b1;
      if (wcnt >= mem_lat) begin
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = imem_bus.imem_addr + 32'h13 + mem_salt;
        wcnt = 0;
      end else begin
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        wcnt++;
      end
    end else begin
      imem_bus.imem_ack   = spurious;
      imem_bus.imem_rdata = 32'hDEAD_BEEF;
      wcnt = 0;
    end
  end

  // Scoreboard helper
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic s, input logic jf, input logic bf,
                       input logic [31:0] jt, input logic [31:0] bt);
    stall         = s;
    jal_flush     = jf;
    branch_flush  = bf;
    jal_target    = jt;
    branch_target = bt;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int lat, input logic [31:0] salt, input logic spur);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    mem_lat  = lat;
    mem_salt = salt;
    spurious = spur;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        s;
    logic        jf;
    logic        bf;
    logic [31:0] jt;
    logic [31:0] bt;
    logic        req;
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [1:0]  st;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  task automatic setv(input int i, input logic s, input logic jf, input logic bf,
                      input logic [31:0] jt, input logic [31:0] bt, input logic r,
                      input logic [31:0] a, input logic [31:0] in, input logic [31:0] p,
                      input logic [1:0] st);
    vecs[i] = '{s, jf, bf, jt, bt, r, a, in, p, st};
  endtask

  int stale_hits;

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Zero-latency stream, stall to full queue, flush+stall with unaligned target, dual flush.
    setv( 0, 0,0,0, 32'h0,   32'h0,   0, 32'h000, 32'h013, 32'h000, S_IDLE);
    setv( 1, 0,0,0, 32'h0,   32'h0,   1, 32'h000, 32'h013, 32'h000, S_REQ);
    setv( 2, 0,0,0, 32'h0,   32'h0,   1, 32'h004, 32'h013, 32'h000, S_REQ);
    setv( 3, 0,0,0, 32'h0,   32'h0,   1, 32'h008, 32'h013, 32'h000, S_REQ);
    setv( 4, 0,0,0, 32'h0,   32'h0,   1, 32'h00C, 32'h017, 32'h004, S_REQ);
    setv( 5, 0,0,0, 32'h0,   32'h0,   1, 32'h010, 32'h01B, 32'h008, S_REQ);
    setv( 6, 1,0,0, 32'h0,   32'h0,   1, 32'h014, 32'h01F, 32'h00C, S_REQ);
    setv( 7, 1,0,0, 32'h0,   32'h0,   0, 32'h014, 32'h01F, 32'h00C, S_IDLE);
    setv( 8, 1,0,0, 32'h0,   32'h0,   0, 32'h014, 32'h01F, 32'h00C, S_IDLE);
    setv( 9, 1,0,0, 32'h0,   32'h0,   0, 32'h014, 32'h01F, 32'h00C, S_IDLE);
    setv(10, 0,0,0, 32'h0,   32'h0,   0, 32'h014, 32'h01F, 32'h00C, S_IDLE);
    setv(11, 0,0,0, 32'h0,   32'h0,   0, 32'h014, 32'h023, 32'h010, S_IDLE);
    setv(12, 0,0,0, 32'h0,   32'h0,   1, 32'h018, 32'h027, 32'h014, S_REQ);
    setv(13, 0,0,0, 32'h0,   32'h0,   1, 32'h01C, 32'h013, 32'h014, S_REQ);
    setv(14, 0,0,0, 32'h0,   32'h0,   1, 32'h020, 32'h02B, 32'h018, S_REQ);
    setv(15, 0,0,0, 32'h0,   32'h0,   1, 32'h024, 32'h02F, 32'h01C, S_REQ);
    setv(16, 1,0,1, 32'h0,   32'h103, 1, 32'h028, 32'h033, 32'h020, S_REQ);
    setv(17, 0,0,0, 32'h0,   32'h0,   0, 32'h028, 32'h013, 32'h020, S_IDLE);
    setv(18, 0,0,0, 32'h0,   32'h0,   1, 32'h100, 32'h013, 32'h020, S_REQ);
    setv(19, 0,0,0, 32'h0,   32'h0,   1, 32'h104, 32'h013, 32'h020, S_REQ);
    setv(20, 0,0,0, 32'h0,   32'h0,   1, 32'h108, 32'h113, 32'h100, S_REQ);
    setv(21, 0,1,1, 32'h200, 32'h300, 1, 32'h10C, 32'h117, 32'h104, S_REQ);
    setv(22, 0,0,0, 32'h0,   32'h0,   0, 32'h10C, 32'h013, 32'h104, S_IDLE);
    setv(23, 0,0,0, 32'h0,   32'h0,   1, 32'h300, 32'h013, 32'h104, S_REQ);
    setv(24, 0,0,0, 32'h0,   32'h0,   1, 32'h304, 32'h013, 32'h104, S_REQ);
    setv(25, 0,0,0, 32'h0,   32'h0,   1, 32'h308, 32'h313, 32'h300, S_REQ);

    // Spurious acks while imem_req is low must be ignored throughout the table.
    do_reset(0, 32'h0, 1'b1);
    for (int i = 0; i < NV; i++) begin
      if (i > 0) next_cycle();
      drive(vecs[i].s, vecs[i].jf, vecs[i].bf, vecs[i].jt, vecs[i].bt);
      @(negedge clk);
      chk($sformatf("v%0d_req", i),   {31'h0, imem_bus.imem_req}, {31'h0, vecs[i].req});
      chk($sformatf("v%0d_addr", i),  imem_bus.imem_addr, vecs[i].addr);
      chk($sformatf("v%0d_inst", i),  inst, vecs[i].inst);
      chk($sformatf("v%0d_pc", i),    pc, vecs[i].pc);
      chk($sformatf("v%0d_state", i), {30'h0, dbg_state}, {30'h0, vecs[i].st});
    end
    chk("jal_target_never_fetched", {31'h0, saw_200}, 32'h0);

    // Delayed ack (3 wait cycles) with branch_flush while the request is pending.
    do_reset(3, 32'h1000, 1'b0);
    stale_hits = 0;
    next_cycle();
    @(negedge clk);
    chk("dly_c1_req", {31'h0, imem_bus.imem_req}, 32'h1);
    chk("dly_c1_addr", imem_bus.imem_addr, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h100);
    @(negedge clk);
    chk("dly_c2_addr", imem_bus.imem_addr, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("dly_c3_state", {30'h0, dbg_state}, {30'h0, S_DROP});
    chk("dly_c3_req", {31'h0, imem_bus.imem_req}, 32'h1);
    chk("dly_c3_addr_held", imem_bus.imem_addr, 32'h0);
    chk("dly_c3_inst_nop", inst, 32'h13);
    next_cycle();
    @(negedge clk);
    chk("dly_c4_addr_held", imem_bus.imem_addr, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("dly_c5_state", {30'h0, dbg_state}, {30'h0, S_IDLE});
    chk("dly_c5_req", {31'h0, imem_bus.imem_req}, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("dly_c6_req", {31'h0, imem_bus.imem_req}, 32'h1);
    chk("dly_c6_addr", imem_bus.imem_addr, 32'h100);
    for (int c = 7; c <= 11; c++) begin
      next_cycle();
      @(negedge clk);
      if (inst == 32'h1013) stale_hits++;
    end
    chk("dly_stale_never_seen", stale_hits, 32'h0);
    chk("dly_c11_inst", inst, 32'h1113);
    chk("dly_c11_pc", pc, 32'h100);

    // Reset while a request is waiting for its ack.
    next_cycle();
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("rst_mid_req", {31'h0, imem_bus.imem_req}, 32'h0);
    chk("rst_mid_addr", imem_bus.imem_addr, 32'h0);
    chk("rst_mid_state", {30'h0, dbg_state}, {30'h0, S_IDLE});
    chk("rst_mid_inst", inst, 32'h13);
    chk("rst_mid_pc", pc, 32'h0);

    // jal redirect to the last word, fetch address wraps to zero.
    do_reset(0, 32'h0, 1'b0);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0);
    @(negedge clk);
    chk("wrap_c1_addr", imem_bus.imem_addr, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("wrap_c2_req", {31'h0, imem_bus.imem_req}, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("wrap_c3_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
    next_cycle();
    @(negedge clk);
    chk("wrap_c4_addr", imem_bus.imem_addr, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("wrap_c5_inst", inst, 32'h0000_000F);
    chk("wrap_c5_pc", pc, 32'hFFFF_FFFC);
    next_cycle();
    @(negedge clk);
    chk("wrap_c6_inst", inst, 32'h13);
    chk("wrap_c6_pc", pc, 32'h0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
